// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads two bytes per 16-bit big-endian
// instruction from a combinational byte memory and hands the word to decode via valid/ready.
module instruction_fetch_sequencer #(
    parameter int                ADDR_W    = 16,
    parameter int                MEM_BYTES = 128,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [ADDR_W-1:0] MemAdresa,
    input  logic [7:0]        MemByte,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic [15:0]       Instruksioni,
    output logic [ADDR_W-1:0] InstrPC,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic              AddrFault
);

    typedef enum logic [1:0] {S_HI, S_LO, S_OUT, S_FAULT} state_t;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus2;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              redirect, tgt_bad, accept, seq_bad;

    // Extra bit keeps the odd-byte address from wrapping back into range.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} + {{ADDR_W{1'b0}}, 1'b1}) >= MEM_LIMIT;
    endfunction

    assign pc_plus2 = pc_q + ADDR_W'(2);
    assign redirect = BranchTaken && (state_q != S_FAULT);
    assign tgt_bad  = BranchTarget[0] || out_of_range(BranchTarget);
    assign accept   = (state_q == S_OUT) && InstrReady;
    assign seq_bad  = out_of_range(pc_plus2);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_HI;
            pc_q    <= RESET_PC;
            hi_q    <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hi_q    <= hi_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Next state and PC; a bad redirect or bad sequential PC leaves the PC untouched.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect) begin
            if (tgt_bad) begin
                state_d = S_FAULT;
            end else begin
                state_d = S_HI;
                pc_d    = BranchTarget;
            end
        end else begin
            case (state_q)
                S_HI:  if (!Stall) state_d = S_LO;
                S_LO:  if (!Stall) state_d = S_OUT;
                S_OUT: begin
                    if (accept) begin
                        if (seq_bad) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_HI;
                            pc_d    = pc_plus2;
                        end
                    end
                end
                default: state_d = S_FAULT;
            endcase
        end
    end

    always_comb begin
        MemAdresa = (state_q == S_LO) ? (pc_q + ADDR_W'(1)) : pc_q;
        hi_d      = hi_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        if (state_q == S_FAULT) begin
            valid_d = 1'b0;
            fault_d = 1'b1;
        end else if (redirect) begin
            valid_d = 1'b0;
            if (tgt_bad) fault_d = 1'b1;
        end else begin
            case (state_q)
                S_HI: begin
                    if (!Stall) hi_d = MemByte;
                end
                S_LO: begin
                    if (!Stall) begin
                        instr_d = {hi_q, MemByte};
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                    end
                end
                S_OUT: begin
                    if (accept) begin
                        valid_d = 1'b0;
                        if (seq_bad) fault_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Instruksioni = instr_q;
    assign InstrPC      = ipc_q;
    assign InstrValid   = valid_q;
    assign AddrFault    = fault_q;

endmodule
